// File: rtl/uart_fifo.sv
// 16x8 first-word-fall-through FIFO for the UART transmit/receive paths.
// Define UART_FIFO_STICKY_FLAGS_EN to make overrun/underrun latch until reset.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    input  logic             push,
    input  logic             pop,
    output logic             underrun,
    output logic             overrun,
    output logic [AW:0]      count
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;

    logic full;
    logic empty;
    logic do_push;
    logic do_pop;
    logic overrun_event;
    logic underrun_event;

    always_comb begin
        full           = (count == FULL_COUNT);
        empty          = (count == '0);
        do_pop         = pop && !empty;
        // When full, a simultaneous pop frees the slot the push lands in.
        do_push        = push && (!full || pop);
        overrun_event  = push && full && !pop;
        underrun_event = pop && empty;
    end

    assign data_out = mem[rp];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wp] <= data_in;
                wp      <= wp + 1'b1;
            end
            if (do_pop) begin
                rp <= rp + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overrun  <= 1'b0;
            underrun <= 1'b0;
        end else begin
`ifdef UART_FIFO_STICKY_FLAGS_EN
            if (overrun_event) begin
                overrun <= 1'b1;
            end
            if (underrun_event) begin
                underrun <= 1'b1;
            end
`else
            overrun  <= overrun_event;
            underrun <= underrun_event;
`endif
        end
    end

endmodule

// File: tb/tb_uart_fifo.sv
// Directed self-checking bench for uart_fifo (default pulse-flag build).
module tb_uart_fifo;

    logic       clk;
    logic       reset;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       push;
    logic       pop;
    logic       underrun;
    logic       overrun;
    logic [4:0] count;

    int passed;
    int total;

    uart_fifo #(.WIDTH(8), .DEPTH(16), .AW(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in),
        .data_out (data_out),
        .push     (push),
        .pop      (pop),
        .underrun (underrun),
        .overrun  (overrun),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after an edge; outputs are sampled there too.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; push = 1'b0; pop = 1'b0; data_in = '0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            data_in = 8'(8'hE0 + i); push = 1'b1;
            tick();
        end
        push = 1'b0;
        total++;
        if (count !== 5'd3) $display("FAIL pre_reset_count got=%0d exp=3", count);
        else passed++;
        reset = 1'b1; push = 1'b1; pop = 1'b1; data_in = 8'h77;
        tick();
        reset = 1'b0; push = 1'b0; pop = 1'b0;
        total++;
        if (count !== 5'd0) $display("FAIL reset_count got=%0d exp=0", count);
        else passed++;
        total++;
        if (data_out !== 8'h00) $display("FAIL reset_data_out got=%h exp=00", data_out);
        else passed++;
        total++;
        if (overrun !== 1'b0 || underrun !== 1'b0)
            $display("FAIL reset_flags got ovr=%b und=%b exp=0/0", overrun, underrun);
        else passed++;
    endtask

    task automatic test_pop_empty;
        pop = 1'b1;
        tick();
        pop = 1'b0;
        total++;
        if (underrun !== 1'b1) $display("FAIL pop_empty_underrun got=%b exp=1", underrun);
        else passed++;
        total++;
        if (count !== 5'd0) $display("FAIL pop_empty_count got=%0d exp=0", count);
        else passed++;
        tick();
        total++;
        if (underrun !== 1'b0) $display("FAIL pop_empty_underrun_clear got=%b exp=0", underrun);
        else passed++;
    endtask

    task automatic test_fill;
        for (int i = 0; i < 18; i++) begin
            data_in = 8'(i); push = 1'b1;
            tick();
            total++;
            if (count !== 5'((i < 16) ? i + 1 : 16))
                $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count, (i < 16) ? i + 1 : 16);
            else passed++;
            total++;
            if (overrun !== (i >= 16))
                $display("FAIL fill_overrun[%0d] got=%b exp=%b", i, overrun, i >= 16);
            else passed++;
            total++;
            if (data_out !== 8'h00) $display("FAIL fill_head[%0d] got=%h exp=00", i, data_out);
            else passed++;
        end
        push = 1'b0;
        tick();
        total++;
        if (overrun !== 1'b0 || count !== 5'd16)
            $display("FAIL fill_idle got ovr=%b cnt=%0d exp=0/16", overrun, count);
        else passed++;
    endtask

    task automatic test_drain;
        for (int i = 0; i < 18; i++) begin
            if (i < 16) begin
                total++;
                if (data_out !== 8'(i)) $display("FAIL drain_head[%0d] got=%h exp=%h", i, data_out, 8'(i));
                else passed++;
            end
            pop = 1'b1;
            tick();
            total++;
            if (count !== 5'((i < 16) ? 15 - i : 0))
                $display("FAIL drain_count[%0d] got=%0d exp=%0d", i, count, (i < 16) ? 15 - i : 0);
            else passed++;
            total++;
            if (underrun !== (i >= 16))
                $display("FAIL drain_underrun[%0d] got=%b exp=%b", i, underrun, i >= 16);
            else passed++;
        end
        pop = 1'b0;
        tick();
        total++;
        if (underrun !== 1'b0) $display("FAIL drain_idle_underrun got=%b exp=0", underrun);
        else passed++;
    endtask

    task automatic test_alternate;
        // Offset both pointers by 5 so the 16-word burst wraps the array.
        for (int i = 0; i < 5; i++) begin
            data_in = 8'(8'hC0 + i); push = 1'b1;
            tick();
        end
        push = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pop = 1'b1;
            tick();
        end
        pop = 1'b0;
        total++;
        if (count !== 5'd0) $display("FAIL alt_offset_count got=%0d exp=0", count);
        else passed++;
        for (int i = 0; i < 18; i++) begin
            data_in = 8'(8'h40 + i); push = 1'b1;
            tick();
            push = 1'b0;
            total++;
            if (count !== 5'((i < 16) ? i + 1 : 16) || overrun !== (i >= 16))
                $display("FAIL alt_push[%0d] got cnt=%0d ovr=%b exp cnt=%0d ovr=%b",
                         i, count, overrun, (i < 16) ? i + 1 : 16, i >= 16);
            else passed++;
            tick();
            total++;
            if (overrun !== 1'b0) $display("FAIL alt_push_idle[%0d] got ovr=%b exp=0", i, overrun);
            else passed++;
        end
        for (int i = 0; i < 16; i++) begin
            total++;
            if (data_out !== 8'(8'h40 + i))
                $display("FAIL alt_head[%0d] got=%h exp=%h", i, data_out, 8'(8'h40 + i));
            else passed++;
            pop = 1'b1;
            tick();
            pop = 1'b0;
            total++;
            if (count !== 5'(15 - i)) $display("FAIL alt_pop_count[%0d] got=%0d exp=%0d", i, count, 15 - i);
            else passed++;
            tick();
        end
        total++;
        if (underrun !== 1'b0) $display("FAIL alt_end_underrun got=%b exp=0", underrun);
        else passed++;
    endtask

    task automatic test_simultaneous;
        for (int i = 0; i < 16; i++) begin
            data_in = 8'(8'h80 + i); push = 1'b1;
            tick();
        end
        data_in = 8'hAA; push = 1'b1; pop = 1'b1;
        tick();
        push = 1'b0; pop = 1'b0;
        total++;
        if (count !== 5'd16) $display("FAIL full_pushpop_count got=%0d exp=16", count);
        else passed++;
        total++;
        if (overrun !== 1'b0) $display("FAIL full_pushpop_overrun got=%b exp=0", overrun);
        else passed++;
        total++;
        if (data_out !== 8'h81) $display("FAIL full_pushpop_head got=%h exp=81", data_out);
        else passed++;
        for (int i = 0; i < 16; i++) begin
            logic [7:0] exp_head;
            exp_head = (i < 15) ? 8'(8'h81 + i) : 8'hAA;
            total++;
            if (data_out !== exp_head) $display("FAIL full_drain_head[%0d] got=%h exp=%h", i, data_out, exp_head);
            else passed++;
            pop = 1'b1;
            tick();
        end
        pop = 1'b0;
        total++;
        if (count !== 5'd0) $display("FAIL full_drain_count got=%0d exp=0", count);
        else passed++;
        data_in = 8'h55; push = 1'b1; pop = 1'b1;
        tick();
        push = 1'b0; pop = 1'b0;
        total++;
        if (count !== 5'd1) $display("FAIL empty_pushpop_count got=%0d exp=1", count);
        else passed++;
        total++;
        if (data_out !== 8'h55) $display("FAIL empty_pushpop_head got=%h exp=55", data_out);
        else passed++;
        total++;
        if (underrun !== 1'b1) $display("FAIL empty_pushpop_underrun got=%b exp=1", underrun);
        else passed++;
        tick();
        total++;
        if (underrun !== 1'b0 || count !== 5'd1)
            $display("FAIL empty_pushpop_idle got und=%b cnt=%0d exp=0/1", underrun, count);
        else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        reset = 1'b1; push = 1'b0; pop = 1'b0; data_in = '0;
        test_reset();
        test_pop_empty();
        test_fill();
        test_drain();
        test_alternate();
        test_simultaneous();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
